// File: rtl/wl_frame_store.sv
// Single-clock frame store: reset synchronizer, write port, and a registered read port with a valid pipeline.
// Optional macro WL_FRAME_STORE_WR_FIRST_EN makes a same-cycle read and write to one address return the write data.
module wl_frame_store #(
  parameter int DW         = 8,
  parameter int AW         = 21,
  parameter int DEPTH      = 2073600,
  parameter int OREG       = 1,
  parameter int RST_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  output logic          rst_b_out,
  input  logic [DW-1:0] dina,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic          enb,
  input  logic          regceb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb,
  output logic          vldb
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [RST_STAGES-1:0] sync_q;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_en;
  logic [DW-1:0]         rd_word;
  logic [DW-1:0]         lat_q;
  logic                  v1_q;
  logic [DW-1:0]         mem [DEPTH];

  // Clears asynchronously, releases only after RST_STAGES clean edges.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[RST_STAGES-2:0], 1'b1};
    end
  end

  assign rst_b_out = sync_q[RST_STAGES-1];

  assign wr_ok = ({1'b0, addra} < DEPTH_L);
  assign rd_ok = ({1'b0, addrb} < DEPTH_L);
  assign wr_en = wea & rst_b_out & wr_ok;

  // Frame contents are never reset; only the read pipeline is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addra] <= dina;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[addrb];
    end
`ifdef WL_FRAME_STORE_WR_FIRST_EN
    if (wr_en && (addra == addrb)) begin
      rd_word = dina;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_b_out) begin
    if (!rst_b_out) begin
      lat_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= enb;
      if (enb) begin
        lat_q <= rd_word;
      end
    end
  end

  // vldb is a pure valid flag with no ready: high for exactly one cycle per
  // enabled read, doutb is meaningful only in that cycle, and the sink must
  // accept it then (regceb=0 freezes both doutb and vldb together).
  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] dout_q;
      logic          v2_q;

      always_ff @(posedge clk or negedge rst_b_out) begin
        if (!rst_b_out) begin
          dout_q <= '0;
          v2_q   <= 1'b0;
        end else if (regceb) begin
          dout_q <= lat_q;
          v2_q   <= v1_q;
        end
      end

      assign doutb = dout_q;
      assign vldb  = v2_q;
    end else begin : g_bypass
      assign doutb = lat_q;
      assign vldb  = v1_q;
    end
  endgenerate

endmodule

// File: tb/tb_wl_frame_store.sv
// Directed bench for wl_frame_store: reset release, raster write/read, frame boundary,
// regceb stall, collision and mid-read reset.
module tb_wl_frame_store;

  localparam int DW = 8;
  localparam int AW = 21;

`ifdef WL_FRAME_STORE_WR_FIRST_EN
  localparam logic [7:0] COLL_EXP = 8'h22;
`else
  localparam logic [7:0] COLL_EXP = 8'h11;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_rd;
  } vec_t;

  logic          clk;
  logic          rst_b;
  logic          rst_b_out;
  logic [DW-1:0] dina;
  logic          wea;
  logic [AW-1:0] addra;
  logic          enb;
  logic          regceb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          vldb;

  logic [DW-1:0] exp_q[$];
  int            checks;
  int            errors;
  int            vld_cnt;
  logic          mon_en;
  vec_t          tbl[16];

  wl_frame_store dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .rst_b_out (rst_b_out),
    .dina      (dina),
    .wea       (wea),
    .addra     (addra),
    .enb       (enb),
    .regceb    (regceb),
    .addrb     (addrb),
    .doutb     (doutb),
    .vldb      (vldb)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wea   = 1'b1;
    addra = a;
    dina  = d;
    tick();
    wea   = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    enb   = 1'b1;
    addrb = a;
    exp_q.push_back(e);
    tick();
    enb   = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  // Scoreboard: every vldb cycle pops one expected word
  always @(negedge clk) begin
    if (mon_en && vldb) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        chk("vld_unexpected", 32'(vldb), 32'(0));
      end else begin
        chk("rd_data", 32'(doutb), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    vld_cnt = 0;
    mon_en  = 1'b0;
    rst_b   = 1'b0;
    dina    = '0;
    wea     = 1'b0;
    addra   = '0;
    enb     = 1'b0;
    regceb  = 1'b1;
    addrb   = '0;

    tbl[0]  = '{21'd0,  8'hA5, 8'hA5};
    tbl[1]  = '{21'd1,  8'hA4, 8'hA4};
    tbl[2]  = '{21'd2,  8'hA7, 8'hA7};
    tbl[3]  = '{21'd3,  8'hA6, 8'hA6};
    tbl[4]  = '{21'd4,  8'hA1, 8'hA1};
    tbl[5]  = '{21'd5,  8'hA0, 8'hA0};
    tbl[6]  = '{21'd6,  8'hA3, 8'hA3};
    tbl[7]  = '{21'd7,  8'hA2, 8'hA2};
    tbl[8]  = '{21'd8,  8'hAD, 8'hAD};
    tbl[9]  = '{21'd9,  8'hAC, 8'hAC};
    tbl[10] = '{21'd10, 8'hAF, 8'hAF};
    tbl[11] = '{21'd11, 8'hAE, 8'hAE};
    tbl[12] = '{21'd12, 8'hA9, 8'hA9};
    tbl[13] = '{21'd13, 8'hA8, 8'hA8};
    tbl[14] = '{21'd14, 8'hAB, 8'hAB};
    tbl[15] = '{21'd15, 8'hAA, 8'hAA};

    // Reset release
    repeat (10) begin
      tick();
      chk("rst_hold", {22'd0, rst_b_out, vldb, doutb}, 32'd0);
    end
    rst_b = 1'b1;
    tick();
    chk("rst_edge1", 32'(rst_b_out), 32'd0);
    tick();
    chk("rst_edge2", 32'(rst_b_out), 32'd1);
    chk("rst_outs", {23'd0, vldb, doutb}, 32'd0);
    mon_en = 1'b1;

    // Raster write then continuous read
    for (int i = 0; i < 16; i++) wr(tbl[i].addr, tbl[i].din);
    vld_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      rd(tbl[i].addr, tbl[i].exp_rd);
      if (i == 0) chk("vld_latency", 32'(vldb), 32'd0);
    end
    drain();
    chk("raster_vld_cnt", 32'(vld_cnt), 32'd16);
    chk("raster_q_empty", 32'(exp_q.size()), 32'd0);

    // Frame boundary
    wr(21'd2073599, 8'h3C);
    wr(21'd2073600, 8'h77);
    rd(21'd2073599, 8'h3C);
    rd(21'd2073600, 8'h00);
    rd(21'd0, 8'hA5);
    drain();

    // Same-cycle collision
    wr(21'd5, 8'h11);
    wea   = 1'b1;
    addra = 21'd5;
    dina  = 8'h22;
    rd(21'd5, COLL_EXP);
    wea   = 1'b0;
    rd(21'd5, 8'h22);
    drain();
    chk("coll_q_empty", 32'(exp_q.size()), 32'd0);

    // regceb stall: stage 1 keeps moving, so addr 1 is overwritten by addr 2
    mon_en = 1'b0;
    enb    = 1'b1;
    addrb  = 21'd0;
    tick();
    addrb  = 21'd1;
    tick();
    chk("stall_c1", {23'd0, vldb, doutb}, {23'd0, 1'b1, 8'hA5});
    addrb  = 21'd2;
    regceb = 1'b0;
    tick();
    chk("stall_c2", {23'd0, vldb, doutb}, {23'd0, 1'b1, 8'hA5});
    enb    = 1'b0;
    regceb = 1'b1;
    tick();
    chk("stall_c3", {23'd0, vldb, doutb}, {23'd0, 1'b1, 8'hA7});
    tick();
    chk("stall_c4", 32'(vldb), 32'd0);
    drain();

    // Mid-read reset, with writes dropped while rst_b_out is low
    enb   = 1'b1;
    addrb = 21'd3;
    tick();
    enb   = 1'b0;
    tick();
    chk("pre_rst", {23'd0, vldb, doutb}, {23'd0, 1'b1, 8'hA6});
    rst_b = 1'b0;
    #1;
    chk("async_clr", {22'd0, rst_b_out, vldb, doutb}, 32'd0);
    wea   = 1'b1;
    addra = 21'd3;
    dina  = 8'hFF;
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    chk("rerst_edge1", 32'(rst_b_out), 32'd0);
    tick();
    chk("rerst_edge2", 32'(rst_b_out), 32'd1);
    wea = 1'b0;
    exp_q.delete();
    vld_cnt = 0;
    mon_en = 1'b1;
    rd(21'd3, 8'hA6);
    drain();
    chk("rerst_vld_cnt", 32'(vld_cnt), 32'd1);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wl_frame_store.md
# wl_frame_store

Single-clock frame buffer for the vision pipeline. It holds one 1920×1080 8-bit frame (2,073,600 locations). The block contains:
- a reset synchronizer that drives its own internal reset and exports it as `rst_b_out`,
- a simple dual-port memory with one write port and one registered read port,
- a valid pipeline that flags when `doutb` carries read data.

Upstream capture writes pixels in raster order; a downstream sink reads the frame back and writes it to file.

## Interface
Parameters:
- `DW`, 8: data width in bits.
- `AW`, 21: address width in bits.
- `DEPTH`, 2073600: number of words; must satisfy DEPTH ≤ 2^AW.
- `OREG`, 1: read output register stage. 1 = enabled, 0 = bypassed.
- `RST_STAGES`, 2: number of reset synchronizer flops; minimum 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  single clock for all logic.
- `rst_b`  in  1  asynchronous, active-low reset.
- `rst_b_out`  out  1  synchronized reset: asserts asynchronously, deasserts synchronously.
- `dina`  in  DW  write data.
- `wea`  in  1  write enable.
- `addra`  in  AW  write address.
- `enb`  in  1  read enable.
- `regceb`  in  1  output-register clock enable; ignored when OREG=0.
- `addrb`  in  AW  read address.
- `doutb`  out  DW  read data.
- `vldb`  out  1  `doutb` holds data from an enabled read.

## Operation
- **Reset synchronizer.** A chain of RST_STAGES flops, all cleared asynchronously by `rst_b`=0. It shifts in 1 on each edge while `rst_b`=1. `rst_b_out` is the last flop of the chain. All other block logic resets from `rst_b_out`.
- **Write.** On a rising edge with `wea`=1, `rst_b_out`=1 and `addra`<DEPTH, `mem[addra]` is loaded with `dina`.
  - Writes with `addra`≥DEPTH are dropped.
  - Writes while `rst_b_out`=0 are dropped.
- **Read stage 1.** On an edge with `enb`=1, the latch register is loaded with `mem[addrb]`. If `addrb`≥DEPTH, it is loaded with 0. With `enb`=0 the latch register holds its value.
- **Read stage 2 (OREG=1).** On an edge with `regceb`=1, `doutb` is loaded from the latch register.
- **OREG=0.** `doutb` is the latch register directly.
- **Valid pipeline.** `enb` is delayed through 1+OREG flops to form `vldb`.
  - When OREG=1, the second delay flop advances only when `regceb`=1.
- **Memory contents.** Not cleared by reset and undefined at power-up.
- **Same-address read and write** in the same cycle: read-first. The read returns the old data unless the macro below is defined.
- **Reset values.** While `rst_b_out`=0:
  - `rst_b_out`=0, `doutb`=0, `vldb`=0,
  - latch register=0, valid flops=0.
- **Reset mid-read.** Asserting reset mid-read clears the pipeline immediately (asynchronous). In-flight reads are lost.

## Timing
- **Reset.** `rst_b` falling forces `rst_b_out`=0 with no clock needed. After `rst_b` rises, `rst_b_out` rises on the RST_STAGES-th rising edge.
- **Write.** The write takes effect at the edge. A read issued on the next cycle returns the new data.
- **Read latency, OREG=1.** `enb` sampled at edge N gives `doutb` and `vldb`=1 after edge N+2, provided `regceb`=1 at N+1.
- **Read latency, OREG=0.** Valid after edge N+1.
- **Back-to-back reads.** Continuous `enb`=1 gives one word per cycle. `vldb` mirrors the `enb` pattern delayed by the latency.
- **regceb=0 (OREG=1).** `doutb` and the stage-2 valid flop freeze.
- **Address range.** No wrap-around inside the block. Address sequencing (0..DEPTH-1) is the client's job.

## Configuration
- `WL_FRAME_STORE_WR_FIRST_EN` defined:
  - a same-cycle read and write to one address returns `dina` (write-first),
  - writes still require `rst_b_out`=1.
- Undefined (default): the same case returns the previous `mem` contents (read-first).

## Test plan
- **Reset release.** Hold `rst_b`=0 for 10 cycles, release, RST_STAGES=2. Expect `rst_b_out`=0, `doutb`=0 and `vldb`=0 throughout reset, and `rst_b_out`=1 after the 2nd edge.
- **Raster write then read.** Write `addra`=0..15 with `dina`=addr^8'hA5. Then read `addrb`=0..15 with continuous `enb`=1, `regceb`=1. Expect `vldb` high for exactly 16 cycles starting 2 edges after the first `enb`, with `doutb` = 8'hA5, 8'hA4, … in order.
- **Frame boundary.** Write 8'h3C at address 2073599 and 8'h77 at address 2073600. Read 2073599 → 8'h3C. Read 2073600 → 8'h00. Address 0 is unaffected.
- **regceb stall.** Read addresses 0,1,2 with `regceb`=0 on the cycle address 1 reaches stage 2. Expect `doutb` to hold addr 0's data one extra cycle and `vldb` to stretch accordingly.
- **Collision.** Preload `mem[5]`=8'h11, then write 8'h22 to address 5 and read address 5 in the same cycle. Expect 8'h11 without the macro and 8'h22 with `WL_FRAME_STORE_WR_FIRST_EN`.
- **Mid-read reset.** Assert `rst_b` one cycle after `enb`. Expect `vldb`=0 and `doutb`=0 immediately. Writes during reset are dropped: a later read shows the earlier contents.
